// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the microwave countdown timer controller.
// Contents: FSM state encoding (visible on state_o) and the moduli of the
// three countdown digits driven by the controller.
package timer_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARM   = 3'd2,
        COOK  = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Digit moduli of the counter chain: sec ones, sec tens, minutes.
    localparam int SEC_ONES_MOD = 10;
    localparam int SEC_TENS_MOD = 6;
    localparam int MIN_MOD      = 10;

endpackage

// File: rtl/timer_ctrl_tick.sv
// tick_gen: prescaler producing a one-cycle tick every TICK_DIV clocks.
// Ports:
//   clk, clrn : clock, asynchronous active-low reset
//   clr       : force the count to 0 (takes priority over hold)
//   hold      : freeze the count, preserving the tick phase
//   tick      : high for one cycle when the count is at TICK_DIV-1
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic clrn,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int               CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0]    CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            tick  = (cnt_q == CNT_MAX);
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: sequencing controller for the microwave countdown timer.
// Ports:
//   clk, clrn                     : clock, asynchronous active-low reset
//   key_start, key_stop           : keypad levels (rising edges detected here)
//   door_closed                   : 1 = door closed
//   sec_ones, sec_tens, min_ones  : current digits from the datapath
//   loadn                         : active-low one-cycle load strobe
//   en_sec_ones/en_sec_tens/en_min: per-digit decrement enables (borrow chain)
//   mag_on, done                  : magnetron drive, cooking-finished flag
//   state_o                       : current FSM state
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int DONE_HOLD = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_start,
    input  logic       key_stop,
    input  logic       door_closed,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    output logic       loadn,
    output logic       en_sec_ones,
    output logic       en_sec_tens,
    output logic       en_min,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state_o
);

    localparam int            HW        = $clog2(DONE_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

    state_e        state_q, state_d;
    logic          key_start_q, key_stop_q;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          mag_on_q, mag_on_d;
    logic          done_q, done_d;
    logic          start_p, stop_p, all_zero;
    logic          pre_clr, pre_hold, tick;

    assign start_p  = key_start & ~key_start_q;
    assign stop_p   = key_stop  & ~key_stop_q;
    assign all_zero = (sec_ones == 4'd0) & (sec_tens == 4'd0) & (min_ones == 4'd0);

    // Prescaler only advances while cooking or while the done flag is held.
    assign pre_hold = !((state_q == COOK) || (state_q == DONE));

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .clrn (clrn),
        .clr  (pre_clr),
        .hold (pre_hold),
        .tick (tick)
    );

    // State register plus edge-detect, hold counter and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            key_start_q <= 1'b0;
            key_stop_q  <= 1'b0;
            hold_cnt_q  <= '0;
            mag_on_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_start_q <= key_start;
            key_stop_q  <= key_stop;
            hold_cnt_q  <= hold_cnt_d;
            mag_on_q    <= mag_on_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic. Stop always beats a simultaneous start.
    always_comb begin
        state_d    = state_q;
        pre_clr    = 1'b0;
        hold_cnt_d = '0;
        case (state_q)
            IDLE:  if (start_p && door_closed && !stop_p) state_d = LOAD;
            LOAD:  state_d = ARM;
            ARM: begin
                if (all_zero) begin
                    state_d = IDLE;
                end else begin
                    pre_clr = 1'b1;
                    state_d = COOK;
                end
            end
            COOK: begin
                if (all_zero) begin
                    pre_clr = 1'b1;
                    state_d = DONE;
                end else if (stop_p || !door_closed) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (stop_p)                      state_d = IDLE;
                else if (start_p && door_closed) state_d = COOK;
            end
            DONE: begin
                hold_cnt_d = hold_cnt_q;
                if (start_p || stop_p) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (hold_cnt_q == HOLD_LAST) state_d = IDLE;
                    else                         hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Enables ripple combinationally so a borrow crosses all
    // digits in the tick cycle; all_zero blocks any decrement at 0:00.
    always_comb begin
        loadn       = (state_q != LOAD);
        en_sec_ones = (state_q == COOK) & tick & ~all_zero;
        en_sec_tens = en_sec_ones & (sec_ones == 4'd0);
        en_min      = en_sec_tens & (sec_tens == 4'd0);
        mag_on_d    = (state_d == COOK);
        done_d      = (state_d == DONE);
    end

    assign mag_on  = mag_on_q;
    assign done    = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl (TICK_DIV=4, DONE_HOLD=2).
// A behavioural digit datapath closes the loop; a cycle reference model of
// the controller rules predicts every output at each negedge.
module tb_timer_ctrl;
    import timer_ctrl_pkg::*;

    localparam int TD = 4;
    localparam int DH = 2;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic       key_start = 1'b0, key_stop = 1'b0, door_closed = 1'b1;
    logic [3:0] d_ones = '0, d_tens = '0, d_min = '0;
    logic [3:0] p_ones = '0, p_tens = '0, p_min = '0;
    logic       loadn, en_sec_ones, en_sec_tens, en_min, mag_on, done;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state numbers as listed for state_o.
    int m_state = 0, m_pre = 0, m_hold = 0;
    logic m_ks = 1'b0, m_kp = 1'b0;

    timer_ctrl #(.TICK_DIV(TD), .DONE_HOLD(DH)) dut (
        .clk(clk), .clrn(clrn), .key_start(key_start), .key_stop(key_stop),
        .door_closed(door_closed), .sec_ones(d_ones), .sec_tens(d_tens),
        .min_ones(d_min), .loadn(loadn), .en_sec_ones(en_sec_ones),
        .en_sec_tens(en_sec_tens), .en_min(en_min), .mag_on(mag_on),
        .done(done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Behavioural digit datapath: load on loadn, decrement with wrap.
    always @(posedge clk) begin
        if (!loadn) begin
            d_ones <= p_ones;
            d_tens <= p_tens;
            d_min  <= p_min;
        end else begin
            if (en_sec_ones) d_ones <= (d_ones == 0) ? 4'(SEC_ONES_MOD - 1) : d_ones - 4'd1;
            if (en_sec_tens) d_tens <= (d_tens == 0) ? 4'(SEC_TENS_MOD - 1) : d_tens - 4'd1;
            if (en_min)      d_min  <= (d_min  == 0) ? 4'(MIN_MOD - 1)      : d_min  - 4'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return 12'({state_o, loadn, en_sec_ones, en_sec_tens, en_min, mag_on, done});
    endfunction

    function automatic logic [11:0] digits();
        return {d_min, d_tens, d_ones};
    endfunction

    function automatic int secs();
        return int'(d_min) * 60 + int'(d_tens) * 10 + int'(d_ones);
    endfunction

    task automatic model_reset();
        m_state = 0; m_pre = 0; m_hold = 0; m_ks = 1'b0; m_kp = 1'b0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the
    // model with the inputs the DUT samples at the coming posedge.
    task automatic step(input logic ks, input logic kp, input logic door);
        bit tk, az, e0, e1, e2, sp, pp;
        int nxt, pre_n;
        key_start = ks; key_stop = kp; door_closed = door;
        az = (secs() == 0);
        tk = (m_state == 3 || m_state == 5) && (m_pre == TD - 1);
        e0 = (m_state == 3) && tk && !az;
        e1 = e0 && (d_ones == 0);
        e2 = e1 && (d_tens == 0);
        chk("cycle_outputs", outs(),
            12'({3'(m_state), m_state != 1, e0, e1, e2, m_state == 3, m_state == 5}));
        sp = ks && !m_ks;
        pp = kp && !m_kp;
        m_ks = ks; m_kp = kp;
        nxt = m_state;
        pre_n = m_pre;
        if (m_state == 3 || m_state == 5) pre_n = tk ? 0 : m_pre + 1;
        case (m_state)
            0: if (sp && door && !pp) nxt = 1;
            1: nxt = 2;
            2: if (az) nxt = 0; else begin nxt = 3; pre_n = 0; end
            3: if (az) begin nxt = 5; pre_n = 0; m_hold = 0; end
               else if (pp || !door) nxt = 4;
            4: if (pp) nxt = 0; else if (sp && door) nxt = 3;
            5: if (sp || pp) nxt = 0;
               else if (tk) begin
                   m_hold++;
                   if (m_hold == DH) nxt = 0;
               end
            default: nxt = 0;
        endcase
        m_state = nxt;
        m_pre = pre_n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preset(input int m, input int t, input int o);
        p_min = 4'(m); p_tens = 4'(t); p_ones = 4'(o);
    endtask

    initial begin
        int cnt_en, cnt_done, n;
        bit seen;

        // Reset state.
        #2 clrn = 1'b0;
        #1 chk("reset_outputs", outs(), 12'(9'b000_1_000_0_0));
        model_reset();
        repeat (2) @(negedge clk);
        clrn = 1'b1;

        // 1: 0:03 countdown to DONE and back to IDLE.
        preset(0, 0, 3);
        step(1, 0, 1);
        chk("t1_load_strobe", 12'(loadn), 12'(0));
        step(0, 0, 1);
        chk("t1_arm", 12'(state_o), 12'(2));
        step(0, 0, 1);
        chk("t1_cook_mag", 12'({state_o, mag_on}), 12'({3'd3, 1'b1}));
        cnt_en = 0; cnt_done = 0; seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (state_o == 3'd0) begin seen = 1; break; end
            if (en_sec_ones) cnt_en++;
            if (done) cnt_done++;
            step(0, 0, 1);
        end
        chk("t1_reached_idle", 12'(seen), 12'(1));
        chk("t1_en_pulses", 12'(cnt_en), 12'(3));
        chk("t1_done_cycles", 12'(cnt_done), 12'(TD * DH));

        // 2: borrow ripples through all digits at 1:00.
        preset(1, 0, 0);
        step(1, 0, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (en_sec_ones) begin seen = 1; break; end
            step(0, 0, 1);
        end
        chk("t2_tick_seen", 12'(seen), 12'(1));
        chk("t2_ripple", 12'({en_sec_ones, en_sec_tens, en_min}), 12'(3'b111));
        step(0, 0, 1);
        chk("t2_digits_059", digits(), 12'h059);
        step(0, 1, 1);
        chk("t2_stop_pause", 12'(state_o), 12'(4));
        step(0, 0, 1);
        step(0, 1, 1);
        chk("t2_cancel_idle", 12'(state_o), 12'(0));
        step(0, 0, 1);

        // 3: door opens two cycles after a tick; phase preserved on resume.
        preset(0, 1, 1);
        step(1, 0, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (en_sec_ones) begin seen = 1; break; end
            step(0, 0, 1);
        end
        chk("t3_tick_seen", 12'(seen), 12'(1));
        step(0, 0, 1);
        chk("t3_digits_010", digits(), 12'h010);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("t3_pause_mag", 12'({state_o, mag_on}), 12'({3'd4, 1'b0}));
        repeat (5) step(0, 0, 0);
        step(0, 0, 1);
        step(1, 0, 1);
        n = 1; seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (en_sec_ones) begin seen = 1; break; end
            n++;
            step(0, 0, 1);
        end
        chk("t3_resume_tick_delay", 12'(n), 12'(2));
        chk("t3_no_reload", digits(), 12'h010);
        step(0, 0, 1);
        chk("t3_digits_009", digits(), 12'h009);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);

        // 4: start at 0:00 returns to IDLE without cooking.
        preset(0, 0, 0);
        step(1, 0, 1);
        chk("t4_load", 12'(state_o), 12'(1));
        step(0, 0, 1);
        chk("t4_arm", 12'(state_o), 12'(2));
        step(0, 0, 1);
        chk("t4_idle_nomag", 12'({state_o, mag_on}), 12'(0));
        step(0, 0, 1);

        // 5: start and stop together in PAUSE -> IDLE.
        preset(0, 2, 0);
        step(1, 0, 1);
        repeat (6) step(0, 0, 1);
        step(0, 1, 1);
        chk("t5_pause", 12'(state_o), 12'(4));
        step(0, 0, 1);
        step(1, 1, 1);
        chk("t5_stop_wins", 12'({state_o, mag_on}), 12'(0));
        step(0, 0, 1);

        // 6: asynchronous reset in COOK at 0:05.
        preset(0, 0, 5);
        step(1, 0, 1);
        repeat (5) step(0, 0, 1);
        chk("t6_cooking", 12'(state_o), 12'(3));
        clrn = 1'b0;
        #1 chk("t6_reset_immediate", outs(), 12'(9'b000_1_000_0_0));
        model_reset();
        @(negedge clk);
        clrn = 1'b1;
        repeat (10) step(0, 0, 1);
        step(1, 0, 1);
        chk("t6_restart_load", 12'(loadn), 12'(0));

        // Randomised keys, door and presets against the model.
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) preset(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                                     int'($urandom_range(0, 9)));
            step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 19) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
